// File: rtl/alu_pkg.sv
// Shared opcode constants and output-slot state encoding for the arbitrated ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero/neg/lt/err flags; zero latency, no flow control.
module alu_core
  import alu_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [WORD_LEN-1:0] in1,
  input  logic [WORD_LEN-1:0] in2,
  input  logic [2:0]          op,
  output logic [WORD_LEN-1:0] result,
  output logic                zero,
  output logic                neg,
  output logic                lt,
  output logic                err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    // lt is reported for every opcode, including illegal ones
    lt     = $signed(in1) < $signed(in2);
    case (op)
      OP_ADD:  result = in1 + in2;
      OP_SUB:  result = in1 - in2;
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_SLT:  result = {{(WORD_LEN-1){1'b0}}, lt};
      default: err    = 1'b1;
    endcase
    zero = (result == '0);
    neg  = result[WORD_LEN-1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single-slot registered ALU; 1-cycle latency.
// Slot refills in the same cycle it drains; req_ready is held low while the slot is stalled.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [WORD_LEN-1:0] req0_in1,
  input  logic [WORD_LEN-1:0] req0_in2,
  input  logic [2:0]          req0_op,
  input  logic [WORD_LEN-1:0] req1_in1,
  input  logic [WORD_LEN-1:0] req1_in2,
  input  logic [2:0]          req1_op,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [WORD_LEN-1:0] resp_result,
  output logic                resp_zero,
  output logic                resp_neg,
  output logic                resp_lt,
  output logic                resp_err
);

  slot_state_t state, state_nxt;
  logic        last_grant;
  logic        grant;
  logic        can_accept;
  logic        accept;

  logic [WORD_LEN-1:0] alu_in1, alu_in2, alu_result;
  logic [2:0]          alu_op;
  logic                alu_zero, alu_neg, alu_lt, alu_err;

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    grant     = 1'b0;
    // rst_n gates the grant so req_ready stays low throughout reset
    can_accept = rst_n && ((state == ST_EMPTY) || resp_ready);
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
    if (can_accept && (req_valid != 2'b00)) begin
      req_ready[grant] = 1'b1;
    end
    accept = (req_ready != 2'b00);
    if (accept) begin
      state_nxt = ST_FULL;
    end else if ((state == ST_FULL) && resp_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_comb begin
    alu_in1 = grant ? req1_in1 : req0_in1;
    alu_in2 = grant ? req1_in2 : req0_in2;
    alu_op  = grant ? req1_op  : req0_op;
  end

  alu_core #(
    .WORD_LEN(WORD_LEN)
  ) u_core (
    .in1    (alu_in1),
    .in2    (alu_in2),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .lt     (alu_lt),
    .err    (alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_neg    <= 1'b0;
      resp_lt     <= 1'b0;
      resp_err    <= 1'b0;
    end else if (accept) begin
      resp_id     <= grant;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_neg    <= alu_neg;
      resp_lt     <= alu_lt;
      resp_err    <= alu_err;
    end
  end

  assign resp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors with hand-computed results.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        lt;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        lt;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_zero, resp_neg, resp_lt, resp_err;

  int   checks   = 0;
  int   failures = 0;
  logic tb_last;
  vec_t q0[$];
  vec_t q1[$];
  exp_t exp_q[$];

  alu_arbiter #(.WORD_LEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_in1    (req0_in1),
    .req0_in2    (req0_in2),
    .req0_op     (req0_op),
    .req1_in1    (req1_in1),
    .req1_in2    (req1_in2),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_neg    (resp_neg),
    .resp_lt     (resp_lt),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] in1, input logic [31:0] in2,
                               input logic [2:0] op, input logic [31:0] res,
                               input logic z, input logic n, input logic l, input logic e);
    vec_t v;
    v.in1 = in1; v.in2 = in2; v.op = op; v.res = res;
    v.zero = z; v.neg = n; v.lt = l; v.err = e;
    return v;
  endfunction

  function automatic exp_t mke(input logic id, input vec_t v);
    exp_t x;
    x.id = id; x.res = v.res; x.zero = v.zero; x.neg = v.neg; x.lt = v.lt; x.err = v.err;
    return x;
  endfunction

  // Monitor: every completed response handshake pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got id=%0d result=%0h expected no response",
                   resp_id, resp_result);
        end else begin
          e = exp_q.pop_front();
          check("resp", {27'd0, resp_id, resp_result, resp_zero, resp_neg, resp_lt, resp_err},
                {27'd0, e});
        end
      end
    end
  end

  // Presents queued vectors, predicts round-robin grants, pushes expectations on accept.
  task automatic run_queues();
    int         guard;
    logic       win;
    logic       took;
    logic [1:0] exp_rdy;
    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 40) begin
      guard++;
      req_valid = {q1.size() > 0, q0.size() > 0};
      if (q0.size() > 0) begin
        req0_in1 = q0[0].in1; req0_in2 = q0[0].in2; req0_op = q0[0].op;
      end
      if (q1.size() > 0) begin
        req1_in1 = q1[0].in1; req1_in2 = q1[0].in2; req1_op = q1[0].op;
      end
      win     = (req_valid == 2'b11) ? ~tb_last : req_valid[1];
      exp_rdy = win ? 2'b10 : 2'b01;
      @(negedge clk);
      check("grant", {62'd0, req_ready}, {62'd0, exp_rdy});
      took = (req_ready != 2'b00);
      if (took) begin
        if (win) begin
          exp_q.push_back(mke(1'b1, q1[0]));
          void'(q1.pop_front());
        end else begin
          exp_q.push_back(mke(1'b0, q0[0]));
          void'(q0.pop_front());
        end
        tb_last = win;
      end
      @(posedge clk);
      #1;
      if (took) check("latency_valid", {63'd0, resp_valid}, 64'd1);
    end
    check("run_bound", q0.size() + q1.size(), 64'd0);
    req_valid = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    resp_ready = 1'b0;
    req0_in1 = '0; req0_in2 = '0; req0_op = '0;
    req1_in1 = '0; req1_in2 = '0; req1_op = '0;
    tb_last = 1'b1;
    #2;
    check("reset_outputs",
          {25'd0, resp_valid, req_ready, resp_id, resp_result, resp_zero, resp_neg, resp_lt, resp_err},
          64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 2'b00;
    resp_ready = 1'b1;

    // Single op: 5 - 7 on requester 0
    q0.push_back(mkv(32'd5, 32'd7, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0));
    run_queues();

    // Boundaries
    q0.push_back(mkv(32'h8000_0000, 32'd1, OP_SLT, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0));
    q0.push_back(mkv(32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    run_queues();
    q1.push_back(mkv(32'd3, 32'd2, 3'd6, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    run_queues();

    // Contention: grants alternate 0,1,0,1,...
    q0.push_back(mkv(32'd1, 32'd2, OP_ADD, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0));
    q0.push_back(mkv(32'd10, 32'd20, OP_ADD, 32'd30, 1'b0, 1'b0, 1'b1, 1'b0));
    q0.push_back(mkv(32'd9, 32'd9, OP_SUB, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    q0.push_back(mkv(32'hFFFF_FFFF, 32'd0, 3'd7, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1));
    q1.push_back(mkv(32'hF0, 32'h0F, OP_OR, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
    q1.push_back(mkv(32'hF0F0, 32'hFF00, OP_AND, 32'hF000, 1'b0, 1'b0, 1'b1, 1'b0));
    q1.push_back(mkv(32'd3, 32'hFFFF_FFFF, OP_SLT, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    run_queues();
    repeat (2) @(posedge clk);
    #1;
    check("idle_empty", {63'd0, resp_valid}, 64'd0);

    // Backpressure: hold result 3 for 4 cycles, then drain and refill together
    resp_ready = 1'b0;
    req_valid = 2'b01;
    req0_in1 = 32'd1; req0_in2 = 32'd2; req0_op = OP_ADD;
    @(negedge clk);
    check("bp_accept", {62'd0, req_ready}, 64'd1);
    exp_q.push_back(mke(1'b0, mkv(32'd1, 32'd2, OP_ADD, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0)));
    tb_last = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    req1_in1 = 32'd10; req1_in2 = 32'd4; req1_op = OP_SUB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready", {62'd0, req_ready}, 64'd0);
      check("bp_hold", {29'd0, resp_valid, resp_id, resp_result, resp_lt},
            {29'd0, 1'b1, 1'b0, 32'd3, 1'b1});
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_refill", {62'd0, req_ready}, 64'd2);
    exp_q.push_back(mke(1'b1, mkv(32'd10, 32'd4, OP_SUB, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0)));
    tb_last = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("bp_refilled", {30'd0, resp_valid, resp_id, resp_result}, {30'd0, 1'b1, 1'b1, 32'd6});
    @(posedge clk);
    #1;
    check("bp_drain", {63'd0, resp_valid}, 64'd0);

    // Reset mid-run while FULL
    resp_ready = 1'b0;
    req_valid = 2'b01;
    req0_in1 = 32'd2; req0_in2 = 32'd2; req0_op = OP_ADD;
    @(negedge clk);
    check("rst_fill", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    check("rst_full", {63'd0, resp_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {29'd0, resp_valid, req_ready, resp_result}, 64'd0);
    exp_q.delete();
    tb_last = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    q0.push_back(mkv(32'd7, 32'd8, OP_ADD, 32'd15, 1'b0, 1'b0, 1'b1, 1'b0));
    q1.push_back(mkv(32'hF0, 32'h0F, OP_OR, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
    run_queues();

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
